// File: rtl/interface_hcsr04_uc.sv
// HC-SR04 measurement control unit: clear, trigger, await echo/timeout, retry after a gap.
// Optional MEDICAO_CONTINUA_EN adds a `continuo` input for periodic measurement.
module interface_hcsr04_uc #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int ESPERA_CICLOS  = 3_000_000,
  parameter int W_ESPERA       = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       fim_medida,
  input  logic       fim,
  input  logic       fim_timeout,
`ifdef MEDICAO_CONTINUA_EN
  input  logic       continuo,
`endif
  output logic       zera,
  output logic       gera,
  output logic       registra,
  output logic       zera_timeout,
  output logic       conta_timeout,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] tentativa,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_MEDIDA = 4'd3,
    ST_ARMAZENAMENTO = 4'd4,
    ST_FINAL_MEDIDA  = 4'd5,
    ST_FALHA         = 4'd6,
    ST_INTERVALO     = 4'd7,
    ST_ERRO          = 4'd8
  } state_t;

  localparam logic [3:0]          MAX_T    = 4'(MAX_TENTATIVAS);
  localparam logic [W_ESPERA-1:0] GAP_LAST = W_ESPERA'(ESPERA_CICLOS - 1);

  state_t              state, next;
  logic [3:0]          tent_next, tent_inc;
  logic [W_ESPERA-1:0] cnt;
  logic                gap_done;

  assign gap_done  = (cnt == GAP_LAST);
  assign tent_inc  = (tentativa == 4'hF) ? 4'hF : tentativa + 4'd1;
  assign db_estado = state;

  // The gap counter only runs in intervalo, so it is zero on every entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_INICIAL;
      tentativa <= 4'd0;
      cnt       <= '0;
    end else begin
      state     <= next;
      tentativa <= tent_next;
      cnt       <= (state == ST_INTERVALO && !gap_done) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    next          = state;
    tent_next     = tentativa;
    zera          = 1'b0;
    gera          = 1'b0;
    registra      = 1'b0;
    zera_timeout  = 1'b0;
    conta_timeout = 1'b0;
    pronto        = 1'b0;
    erro          = 1'b0;
    case (state)
      ST_INICIAL: begin
        if (medir) begin
          tent_next = 4'd0;
          next      = ST_PREPARACAO;
        end
      end
      ST_PREPARACAO: begin
        zera         = 1'b1;
        zera_timeout = 1'b1;
        next         = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        gera = 1'b1;
        next = ST_ESPERA_MEDIDA;
      end
      ST_ESPERA_MEDIDA: begin
        conta_timeout = 1'b1;
        // A measured echo wins over a simultaneous timeout/overflow.
        if (fim_medida)               next = ST_ARMAZENAMENTO;
        else if (fim_timeout || fim)  next = ST_FALHA;
      end
      ST_ARMAZENAMENTO: begin
        registra = 1'b1;
        next     = ST_FINAL_MEDIDA;
      end
      ST_FINAL_MEDIDA: begin
        pronto = 1'b1;
        next   = ST_INICIAL;
`ifdef MEDICAO_CONTINUA_EN
        if (continuo) begin
          tent_next = 4'd0;
          next      = ST_INTERVALO;
        end
`endif
      end
      ST_FALHA: begin
        tent_next = tent_inc;
        next      = (tent_inc < MAX_T) ? ST_INTERVALO : ST_ERRO;
      end
      ST_INTERVALO: begin
        if (gap_done) next = ST_PREPARACAO;
      end
      ST_ERRO: begin
        erro = 1'b1;
        next = ST_INICIAL;
`ifdef MEDICAO_CONTINUA_EN
        if (continuo) begin
          tent_next = 4'd0;
          next      = ST_INTERVALO;
        end
`endif
      end
      default: next = ST_INICIAL;
    endcase
  end

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Scoreboard bench for interface_hcsr04_uc: stimulus pushes expected results,
// a negedge monitor pops one per pronto/erro pulse.
module tb_interface_hcsr04_uc;
  localparam int MAXT = 3;
  localparam int ESP  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       medir = 1'b0, fim_medida = 1'b0, fim = 1'b0, fim_timeout = 1'b0;
`ifdef MEDICAO_CONTINUA_EN
  logic       continuo = 1'b0;
`endif
  logic       zera, gera, registra, zera_timeout, conta_timeout, pronto, erro;
  logic [3:0] tentativa, db_estado;

  interface_hcsr04_uc #(.MAX_TENTATIVAS(MAXT), .ESPERA_CICLOS(ESP), .W_ESPERA(24)) dut (
    .clock(clock), .reset(reset), .medir(medir), .fim_medida(fim_medida), .fim(fim),
    .fim_timeout(fim_timeout),
`ifdef MEDICAO_CONTINUA_EN
    .continuo(continuo),
`endif
    .zera(zera), .gera(gera), .registra(registra), .zera_timeout(zera_timeout),
    .conta_timeout(conta_timeout), .pronto(pronto), .erro(erro),
    .tentativa(tentativa), .db_estado(db_estado));

  always #5 clock = ~clock;

  typedef struct {
    bit         is_err;
    logic [3:0] tent;
    int         geras;
    int         intervs;
    int         regs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: accumulates activity since the last result, compares on pronto/erro.
  int n_gera = 0, n_int = 0, n_reg = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      n_gera = 0; n_int = 0; n_reg = 0;
    end else begin
      chk("onehot_pulses", 32'($countones({zera, gera, registra, pronto, erro})) <= 1, 32'd1);
      if (gera) n_gera++;
      if (db_estado == 4'd7) n_int++;
      if (registra) n_reg++;
      if (pronto || erro) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: pronto=%0b erro=%0b with empty scoreboard at %0t", pronto, erro, $time);
        end else begin
          e = sb.pop_front();
          chk("result_kind", {30'd0, pronto, erro}, {30'd0, !e.is_err, e.is_err});
          chk("tentativa",   32'(tentativa), 32'(e.tent));
          chk("gera_count",  32'(n_gera),    32'(e.geras));
          chk("interv_cyc",  32'(n_int),     32'(e.intervs));
          chk("registra_cnt", 32'(n_reg),    32'(e.regs));
        end
        n_gera = 0; n_int = 0; n_reg = 0;
      end
    end
  end

  // Every stimulus step lands just after a falling edge.
  task automatic step();
    @(negedge clock); #1;
  endtask

  task automatic push(input bit is_err, input int tent, input int g, input int iv, input int r);
    exp_t e;
    e.is_err = is_err; e.tent = 4'(tent); e.geras = g; e.intervs = iv; e.regs = r;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [3:0] s);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (db_estado == s) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_state: db_estado=%0d never reached %0d at %0t", db_estado, s, $time);
    end
  endtask

  task automatic start();
    medir = 1'b1; step(); medir = 1'b0;
  endtask

  task automatic pulse(input bit fm, input bit ft, input bit fo);
    fim_medida = fm; fim_timeout = ft; fim = fo;
    step();
    fim_medida = 1'b0; fim_timeout = 1'b0; fim = 1'b0;
  endtask

  initial begin
    // Reset then idle
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outputs", 32'({zera, gera, registra, zera_timeout, conta_timeout, pronto, erro, tentativa, db_estado}), 32'd0);
    end

    // Single success with latency checks
    push(0, 0, 1, 0, 1);
    start();
    chk("lat_zera", {31'd0, zera}, 32'd1);
    chk("lat_zera_timeout", {31'd0, zera_timeout}, 32'd1);
    step();
    chk("lat_gera", {31'd0, gera}, 32'd1);
    step();
    chk("lat_conta", {31'd0, conta_timeout}, 32'd1);
    repeat (48) step();
    pulse(1, 0, 0);
    chk("lat_registra", {31'd0, registra}, 32'd1);
    step();
    chk("lat_pronto", {31'd0, pronto}, 32'd1);
    wait_state(4'd0);

    // One retry after timeout
    push(0, 1, 2, ESP, 1);
    start();
    wait_state(4'd3); pulse(0, 1, 0);
    wait_state(4'd3); pulse(1, 0, 0);
    wait_state(4'd0);
    repeat (3) step();

    // Exhaustion
    push(1, MAXT, MAXT, (MAXT - 1) * ESP, 0);
    start();
    for (int a = 0; a < MAXT; a++) begin
      wait_state(4'd3); pulse(0, 1, 0);
    end
    step(); step();
    chk("erro_then_idle", 32'(db_estado), 32'd0);
    chk("erro_tent_hold", 32'(tentativa), 32'(MAXT));

    // Collision: success wins
    push(0, 0, 1, 0, 1);
    start();
    wait_state(4'd3); pulse(1, 1, 0);
    chk("collision_reg", {31'd0, registra}, 32'd1);
    wait_state(4'd0);

    // Overflow treated as failure, then success
    push(0, 1, 2, ESP, 1);
    start();
    wait_state(4'd3); pulse(0, 0, 1);
    chk("overflow_falha", 32'(db_estado), 32'd6);
    wait_state(4'd3); pulse(1, 0, 0);
    wait_state(4'd0);

    // Reset during espera_medida
    start();
    wait_state(4'd3);
    reset = 1'b0; step(); reset = 1'b1;
    chk("rst_wait_state", 32'(db_estado), 32'd0);
    chk("rst_wait_tent", 32'(tentativa), 32'd0);
    // Reset during intervalo
    start();
    wait_state(4'd3); pulse(0, 1, 0);
    wait_state(4'd7);
    step(); step();
    reset = 1'b0; step(); reset = 1'b1;
    chk("rst_int_state", 32'(db_estado), 32'd0);
    chk("rst_int_tent", 32'(tentativa), 32'd0);
    repeat (30) step();

`ifdef MEDICAO_CONTINUA_EN
    push(0, 0, 1, 0, 1);
    push(0, 0, 1, ESP, 1);
    push(0, 0, 1, ESP, 1);
    continuo = 1'b1;
    start();
    for (int a = 0; a < 3; a++) begin
      wait_state(4'd3);
      if (a == 2) continuo = 1'b0;
      pulse(1, 0, 0);
    end
    wait_state(4'd0);
    repeat (5) step();
`endif

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
